// File: rtl/conv_tap_sequencer.sv
// Convolution tap sequencer. It loads the kernel from weight SRAM, then walks each
// header-delimited matrix in input SRAM and issues one tagged read per kernel tap.
module conv_tap_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned KERNEL     = 3,
    parameter int unsigned MAX_DIM    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dut_run,
    output logic                  dut_busy,
    output logic [ADDR_WIDTH-1:0] input_sram_read_address,
    input  logic [DATA_WIDTH-1:0] input_sram_read_data,
    output logic [ADDR_WIDTH-1:0] weights_sram_read_address,
    output logic                  weight_valid,
    output logic [3:0]            weight_idx,
    output logic                  tap_valid,
    output logic [3:0]            tap_idx,
    output logic                  tap_last,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  dim_error
);

    localparam int unsigned CW = $clog2(MAX_DIM + 1);

    localparam logic [ADDR_WIDTH-1:0] WgtLast = ADDR_WIDTH'(KERNEL * KERNEL - 1);
    localparam logic [ADDR_WIDTH-1:0] KStep   = ADDR_WIDTH'(KERNEL);
    localparam logic [ADDR_WIDTH-1:0] KBack   = ADDR_WIDTH'(KERNEL - 1);
    localparam logic [ADDR_WIDTH-1:0] AOne    = ADDR_WIDTH'(1);
    localparam logic [3:0]            TapLast = 4'(KERNEL * KERNEL - 1);
    localparam logic [3:0]            KLast   = 4'(KERNEL - 1);
    localparam logic [DATA_WIDTH-1:0] NMin    = DATA_WIDTH'(KERNEL);
    localparam logic [DATA_WIDTH-1:0] NMax    = DATA_WIDTH'(MAX_DIM);
    localparam logic [DATA_WIDTH-1:0] NStop   = '1;

    typedef enum logic [2:0] {
        StIdle,
        StWgt,
        StHdrReq,
        StHdrChk,
        StConv,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] h_q, h_d;
    logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [CW-1:0]         lim_q, lim_d;
    logic [CW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [3:0]            kc_q, kc_d;
    logic [3:0]            tidx_q, tidx_d;
    logic                  weight_valid_q, weight_valid_d;
    logic [3:0]            weight_idx_q, weight_idx_d;
    logic                  tap_valid_q, tap_valid_d;
    logic [3:0]            tap_idx_q, tap_idx_d;
    logic                  tap_last_q, tap_last_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  dim_error_q, dim_error_d;

    always_comb begin
        state_d        = state_q;
        h_d            = h_q;
        in_addr_d      = in_addr_q;
        base_d         = base_q;
        n_d            = n_q;
        wa_d           = wa_q;
        lim_d          = lim_q;
        r_d            = r_q;
        c_d            = c_q;
        kc_d           = kc_q;
        tidx_d         = tidx_q;
        dim_error_d    = dim_error_q;
        out_addr_d     = tap_last_q ? out_addr_q + AOne : out_addr_q;
        // Tags travel with the read data, so they lag the address by one cycle.
        weight_valid_d = (state_q == StWgt);
        weight_idx_d   = (state_q == StWgt) ? wa_q[3:0] : 4'd0;
        tap_valid_d    = (state_q == StConv);
        tap_idx_d      = (state_q == StConv) ? tidx_q : 4'd0;
        tap_last_d     = (state_q == StConv) && (tidx_q == TapLast);

        unique case (state_q)
            StIdle: begin
                if (dut_run) begin
                    state_d     = StWgt;
                    wa_d        = '0;
                    h_d         = '0;
                    out_addr_d  = '0;
                    dim_error_d = 1'b0;
                end
            end
            StWgt: begin
                if (wa_q == WgtLast) begin
                    state_d   = StHdrReq;
                    wa_d      = '0;
                    in_addr_d = h_q;
                end else begin
                    wa_d = wa_q + AOne;
                end
            end
            StHdrReq: state_d = StHdrChk;
            StHdrChk: begin
                if (input_sram_read_data == NStop) begin
                    state_d = StDone;
                end else if (input_sram_read_data >= NMin && input_sram_read_data <= NMax) begin
                    state_d   = StConv;
                    n_d       = ADDR_WIDTH'(input_sram_read_data);
                    lim_d     = CW'(input_sram_read_data - NMin);
                    in_addr_d = h_q + AOne;
                    base_d    = h_q + AOne;
                    r_d       = '0;
                    c_d       = '0;
                    kc_d      = 4'd0;
                    tidx_d    = 4'd0;
                end else begin
                    state_d     = StDone;
                    dim_error_d = 1'b1;
                end
            end
            StConv: begin
                if (tidx_q == TapLast) begin
                    tidx_d = 4'd0;
                    kc_d   = 4'd0;
                    if (c_q != lim_q) begin
                        c_d       = c_q + CW'(1);
                        base_d    = base_q + AOne;
                        in_addr_d = base_q + AOne;
                    end else if (r_q != lim_q) begin
                        c_d       = '0;
                        r_d       = r_q + CW'(1);
                        base_d    = base_q + KStep;
                        in_addr_d = base_q + KStep;
                    end else begin
                        // Last tap is the bottom-right element at H+N*N; next header follows it.
                        state_d   = StHdrReq;
                        h_d       = in_addr_q + AOne;
                        in_addr_d = in_addr_q + AOne;
                    end
                end else begin
                    tidx_d = tidx_q + 4'd1;
                    if (kc_q == KLast) begin
                        kc_d      = 4'd0;
                        in_addr_d = in_addr_q + n_q - KBack;
                    end else begin
                        kc_d      = kc_q + 4'd1;
                        in_addr_d = in_addr_q + AOne;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            h_q            <= '0;
            in_addr_q      <= '0;
            base_q         <= '0;
            n_q            <= '0;
            wa_q           <= '0;
            lim_q          <= '0;
            r_q            <= '0;
            c_q            <= '0;
            kc_q           <= 4'd0;
            tidx_q         <= 4'd0;
            weight_valid_q <= 1'b0;
            weight_idx_q   <= 4'd0;
            tap_valid_q    <= 1'b0;
            tap_idx_q      <= 4'd0;
            tap_last_q     <= 1'b0;
            out_addr_q     <= '0;
            dim_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_q            <= h_d;
            in_addr_q      <= in_addr_d;
            base_q         <= base_d;
            n_q            <= n_d;
            wa_q           <= wa_d;
            lim_q          <= lim_d;
            r_q            <= r_d;
            c_q            <= c_d;
            kc_q           <= kc_d;
            tidx_q         <= tidx_d;
            weight_valid_q <= weight_valid_d;
            weight_idx_q   <= weight_idx_d;
            tap_valid_q    <= tap_valid_d;
            tap_idx_q      <= tap_idx_d;
            tap_last_q     <= tap_last_d;
            out_addr_q     <= out_addr_d;
            dim_error_q    <= dim_error_d;
        end
    end

    assign dut_busy                  = (state_q != StIdle);
    assign input_sram_read_address   = in_addr_q;
    assign weights_sram_read_address = wa_q;
    assign weight_valid              = weight_valid_q;
    assign weight_idx                = weight_idx_q;
    assign tap_valid                 = tap_valid_q;
    assign tap_idx                   = tap_idx_q;
    assign tap_last                  = tap_last_q;
    assign out_addr                  = out_addr_q;
    assign dim_error                 = dim_error_q;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Bench for conv_tap_sequencer: an input SRAM model plus a reference that derives the expected
// per-cycle tap stream from the header chain in memory.
module tb_conv_tap_sequencer;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MEMSZ = 4096;

    logic          clock = 1'b0;
    logic          reset;
    logic          dut_run;
    logic          dut_busy;
    logic [AW-1:0] input_sram_read_address;
    logic [DW-1:0] input_sram_read_data;
    logic [AW-1:0] weights_sram_read_address;
    logic          weight_valid;
    logic [3:0]    weight_idx;
    logic          tap_valid;
    logic [3:0]    tap_idx;
    logic          tap_last;
    logic [AW-1:0] out_addr;
    logic          dim_error;

    logic [DW-1:0] mem [MEMSZ];

    int exp_valid [MEMSZ];
    int exp_data  [MEMSZ];
    int exp_idx   [MEMSZ];
    int exp_last  [MEMSZ];
    int exp_oaddr [MEMSZ];

    int n_checks = 0;
    int n_fail   = 0;

    conv_tap_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .KERNEL    (3),
        .MAX_DIM   (16)
    ) u_dut (
        .clock                    (clock),
        .reset                    (reset),
        .dut_run                  (dut_run),
        .dut_busy                 (dut_busy),
        .input_sram_read_address  (input_sram_read_address),
        .input_sram_read_data     (input_sram_read_data),
        .weights_sram_read_address(weights_sram_read_address),
        .weight_valid             (weight_valid),
        .weight_idx               (weight_idx),
        .tap_valid                (tap_valid),
        .tap_idx                  (tap_idx),
        .tap_last                 (tap_last),
        .out_addr                 (out_addr),
        .dim_error                (dim_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) input_sram_read_data <= mem[input_sram_read_address];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(dut_busy), 32'd0);
        check_eq({tag, "_iaddr"}, 32'(input_sram_read_address), 32'd0);
        check_eq({tag, "_waddr"}, 32'(weights_sram_read_address), 32'd0);
        check_eq({tag, "_wvalid"}, 32'(weight_valid), 32'd0);
        check_eq({tag, "_widx"}, 32'(weight_idx), 32'd0);
        check_eq({tag, "_tvalid"}, 32'(tap_valid), 32'd0);
        check_eq({tag, "_tidx"}, 32'(tap_idx), 32'd0);
        check_eq({tag, "_tlast"}, 32'(tap_last), 32'd0);
        check_eq({tag, "_oaddr"}, 32'(out_addr), 32'd0);
        check_eq({tag, "_dimerr"}, 32'(dim_error), 32'd0);
    endtask

    // Every element word is unique (and never FFFF), so tap data identifies the address read.
    task automatic fill_mem();
        for (int a = 0; a < MEMSZ; a++) mem[a] = DW'(a) ^ 16'hA000;
    endtask

    // Expected stream, indexed by cycles after the accepting edge: 9 weight reads, then per
    // matrix 2 header cycles plus one tap per cycle, data one cycle after its address.
    task automatic build_model(output int busy_len, output int err);
        int h, n, hdr, o, j;
        for (int i = 0; i < MEMSZ; i++) exp_valid[i] = 0;
        h = 0; hdr = 10; o = 0; err = 0;
        for (int m = 0; m < 64; m++) begin
            n = int'(mem[h]);
            if (n == 32'hFFFF) break;
            if (n < 3 || n > 16) begin
                err = 1;
                break;
            end
            j = 0;
            for (int r = 0; r <= n - 3; r++) begin
                for (int c = 0; c <= n - 3; c++) begin
                    for (int t = 0; t < 9; t++) begin
                        exp_valid[hdr + 3 + j] = 1;
                        exp_data[hdr + 3 + j]  = int'(mem[(h + 1 + (r + t / 3) * n + c + t % 3) % MEMSZ]);
                        exp_idx[hdr + 3 + j]   = t;
                        exp_last[hdr + 3 + j]  = (t == 8) ? 1 : 0;
                        exp_oaddr[hdr + 3 + j] = o % MEMSZ;
                        j++;
                    end
                    o++;
                end
            end
            hdr = hdr + 2 + j;
            h = (h + 1 + n * n) % MEMSZ;
        end
        busy_len = hdr + 2;
    endtask

    task automatic run_case(input string name, input int hold, input int abort_k);
        int blen, err, rst_pending;
        build_model(blen, err);
        rst_pending = 0;
        @(negedge clock);
        dut_run = 1'b1;
        for (int k = 1; k <= blen + 2; k++) begin
            @(negedge clock);
            if (rst_pending != 0) begin
                check_all_zero({name, "_midrst"});
                reset = 1'b0;
                dut_run = 1'b0;
                return;
            end
            check_eq({name, "_busy"}, 32'(dut_busy), 32'(k <= blen));
            check_eq({name, "_wvalid"}, 32'(weight_valid), 32'(k >= 2 && k <= 10));
            if (k >= 2 && k <= 10) check_eq({name, "_widx"}, 32'(weight_idx), 32'(k - 2));
            if (k <= 9) check_eq({name, "_waddr"}, 32'(weights_sram_read_address), 32'(k - 1));
            if (k == 1) check_eq({name, "_dimerr_clr"}, 32'(dim_error), 32'd0);
            check_eq({name, "_tvalid"}, 32'(tap_valid), 32'(exp_valid[k]));
            if (exp_valid[k] != 0) begin
                check_eq({name, "_tdata"}, 32'(input_sram_read_data), 32'(exp_data[k]));
                check_eq({name, "_tidx"}, 32'(tap_idx), 32'(exp_idx[k]));
                check_eq({name, "_tlast"}, 32'(tap_last), 32'(exp_last[k]));
                check_eq({name, "_oaddr"}, 32'(out_addr), 32'(exp_oaddr[k]));
            end
            if (k == blen + 2) check_eq({name, "_dimerr"}, 32'(dim_error), 32'(err));
            if (k == abort_k) begin
                reset = 1'b1;
                rst_pending = 1;
            end
            if (k <= blen) dut_run = (hold != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            else dut_run = 1'b0;
        end
        dut_run = 1'b0;
    endtask

    task automatic setup_a();
        fill_mem();
        mem[0] = 16'd4;
        mem[17] = 16'hFFFF;
    endtask

    task automatic setup_c();
        fill_mem();
        mem[0] = 16'd3;
        mem[10] = 16'd5;
        mem[36] = 16'hFFFF;
    endtask

    initial begin
        int h, n;
        reset = 1'b1;
        dut_run = 1'b0;
        fill_mem();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        setup_a();
        run_case("n4", 0, 0);

        fill_mem();
        mem[0] = 16'hFFFF;
        run_case("empty", 0, 0);

        setup_c();
        run_case("n3n5", 0, 0);

        fill_mem();
        mem[0] = 16'd2;
        run_case("n2", 0, 0);

        fill_mem();
        mem[0] = 16'd17;
        run_case("n17", 0, 0);

        setup_a();
        run_case("hold", 1, 0);

        setup_c();
        run_case("abort", 0, 30);

        setup_a();
        run_case("post_rst", 0, 0);

        for (int trial = 0; trial < 6; trial++) begin
            fill_mem();
            h = 0;
            for (int m = 0; m < int'($urandom_range(1, 3)); m++) begin
                n = int'($urandom_range(3, 7));
                mem[h] = DW'(n);
                h = h + 1 + n * n;
            end
            case ($urandom_range(0, 3))
                0: mem[h] = 16'd1;
                1: mem[h] = 16'd200;
                default: mem[h] = 16'hFFFF;
            endcase
            run_case("rand", int'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
